hwpe_stream_realign_ctrl: RTL and testbench
===========================================

# hwpe_stream_realign_ctrl

Sequencer for a misaligned-stream realigner on an HWPE source path. From a byte base address and a transfer length in words, it drives the realigner's control bundle (`enable`, `realign`, `first`, `last`), the first-beat byte strobe and a start-of-job clear. It advances by observing handshakes on the realigner's input stream. It sits between the source address generator / job FSM and the realigner instance.

## Interface
- `DATA_WIDTH`, 32: stream data width in bits; multiple of 8; `DATA_WIDTH/8` is a power of two.
- `CNT_WIDTH`, 16: width of the transfer-length field.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `clear_i`  in  1  synchronous abort; returns to IDLE.
- `start_i`  in  1  job start; sampled only in IDLE.
- `base_addr_i`  in  32  byte address of first element.
- `trans_size_i`  in  CNT_WIDTH  number of output words N.
- `beat_valid_i`  in  1  realigner input-stream valid (observed).
- `beat_ready_i`  in  1  realigner input-stream ready (observed).
- `ctrl_o`  out  ctrl_realign_t  {enable, realign, first, last} to the realigner.
- `strb_o`  out  DATA_WIDTH/8  byte strobe to the realigner.
- `realign_clear_o`  out  1  one-cycle clear to the realigner.
- `busy_o`  out  1  job in progress.
- `done_o`  out  1  one-cycle job-complete pulse.

## Operation
- Parameters: NB = DATA_WIDTH/8; OW = log2(NB).
- Offset: off = base_addr_i[OW-1:0]. Misaligned: mis = (off != 0).
- Beats: total = N + mis, computed in CNT_WIDTH+1 bits with no overflow.
- Latched at start: off, mis, total.
- States:
  - IDLE:
    - start_i=1 and N≠0 -> RUN; realign_clear_o=1 in that cycle.
    - start_i=1 and N=0 -> DONE; no clear.
  - RUN:
    - beat counter cnt (CNT_WIDTH+1 bits) starts at 0.
    - cnt increments on each beat_valid_i & beat_ready_i.
    - A handshake when cnt = total-1 -> DONE.
  - DONE: done_o=1 for one cycle -> IDLE.
- ctrl_o in RUN:
  - enable=1
  - realign=mis
  - first=(cnt==0)
  - last=(cnt==total-1)
  - first and last are produced for aligned jobs too; realign=0 makes them inert.
- ctrl_o outside RUN: all fields 0.
- strb_o:
  - RUN with cnt==0: '1 << off, i.e. NB-off ones in the upper bytes. This is the rotation amount the realigner latches on `first`.
  - Rest of RUN: '1.
  - Outside RUN: '0.
- busy_o = (state != IDLE).
- start_i while not IDLE is ignored; no queueing.
- clear_i has priority over everything except rst_i:
  - next state IDLE, cnt=0.
  - realign_clear_o=1 in the clear_i cycle.
  - No done_o pulse.
- Simultaneous clear_i and start_i in IDLE: clear_i wins; the job is not started.

## Timing
- Reset (rst_i=1 at a clock edge) -> next cycle:
  - state IDLE, cnt=0.
  - All outputs 0: ctrl_o='0, strb_o='0, realign_clear_o=0, busy_o=0, done_o=0.
- Reset mid-job aborts without done_o. realign_clear_o is not asserted by reset; the realigner has its own reset.
- All outputs are decoded from registered state and cnt, except realign_clear_o, which is combinational on start_i/clear_i in the accepting cycle.
- Start accepted at cycle T: busy_o=1 and ctrl_o.enable=1 from T+1.
- First handshake counts at the earliest in T+1.
- Final handshake at cycle F:
  - done_o=1 at F+1 with ctrl_o='0.
  - busy_o falls at F+2.
  - A new start_i is accepted at F+2 at the earliest.
- Back-to-back jobs: minimum spacing is 2 idle-control cycles (DONE, then IDLE).
- Backpressure: cnt, first, last and strb_o hold while beat_ready_i=0 or beat_valid_i=0.
- total=1 (N=1, aligned): first and last are both 1 on the single beat.
- Maximum N (2^CNT_WIDTH-1) with mis=1: total = 2^CNT_WIDTH; the counter must not wrap.

## Test plan
- DATA_WIDTH=32, base 0x100, N=4, always ready:
  - clear pulse at T; 4 beats at T+1..T+4.
  - realign=0 throughout; first on beat 0, last on beat 3.
  - done_o at T+5.
- base 0x103, N=3:
  - 4 beats; realign=1.
  - Beat 0: first=1, strb_o=4'b1000. Beats 1-3: strb_o=4'b1111. Beat 3: last=1.
  - done_o the cycle after beat 3.
- base 0x102, N=2, beat_ready_i toggling 1-0-1-0:
  - Counter and first/last hold during stalls.
  - strb_o=4'b1100 until the first handshake.
  - Exactly 3 handshakes counted, then done_o.
- start_i with N=0:
  - DONE the next cycle; done_o pulse.
  - enable and realign_clear_o never asserted.
- clear_i after 2 of 5 beats:
  - realign_clear_o=1 in the clear cycle; idle the next cycle with ctrl_o='0 and no done_o.
  - A following start runs a full job with first restarting at cnt=0.
- start_i pulsed while busy: ignored, job length unchanged. rst_i mid-job: all outputs 0 the next cycle.

Source files
------------

// File: rtl/hwpe_stream_realign_ctrl.sv
// Sequencer for the misaligned-stream realigner: latches job geometry at start and walks
// the realigner control bundle/strobe by counting handshakes on its input stream.

package hwpe_stream_realign_pkg;
  typedef struct packed {
    logic enable;
    logic realign;
    logic first;
    logic last;
  } ctrl_realign_t;
endpackage

module hwpe_stream_realign_ctrl
  import hwpe_stream_realign_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [31:0]             base_addr_i,
  input  logic [CNT_WIDTH-1:0]    trans_size_i,
  input  logic                    beat_valid_i,
  input  logic                    beat_ready_i,
  output ctrl_realign_t           ctrl_o,
  output logic [DATA_WIDTH/8-1:0] strb_o,
  output logic                    realign_clear_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned OW  = $clog2(NB);
  localparam int unsigned OwW = (OW == 0) ? 1 : OW;
  localparam logic [CNT_WIDTH:0] CntOne = {{CNT_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [CNT_WIDTH:0] cnt_q;
  logic [CNT_WIDTH:0] total_q;
  logic [OwW-1:0]     off_q;
  logic               mis_q;

  logic [OwW-1:0]     off_d;
  logic               mis_d;
  logic [CNT_WIDTH:0] total_d;
  logic               hs;
  logic               size_nz;
  logic               first_beat;
  logic               last_beat;
  logic               unused_addr;

  assign off_d       = (OW == 0) ? '0 : base_addr_i[OwW-1:0];
  assign mis_d       = (off_d != '0);
  // One extra beat is fetched when the base straddles a word boundary.
  assign total_d     = {1'b0, trans_size_i} + {{CNT_WIDTH{1'b0}}, mis_d};
  assign hs          = beat_valid_i & beat_ready_i;
  assign size_nz     = (trans_size_i != '0);
  assign first_beat  = (cnt_q == '0);
  assign last_beat   = (cnt_q == total_q - CntOne);
  assign unused_addr = ^base_addr_i[31:OW];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      total_q <= '0;
      off_q   <= '0;
      mis_q   <= 1'b0;
    end else if (clear_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            off_q   <= off_d;
            mis_q   <= mis_d;
            total_q <= total_d;
            cnt_q   <= '0;
            state_q <= size_nz ? StRun : StDone;
          end
        end
        StRun: begin
          if (hs) begin
            if (last_beat) begin
              cnt_q   <= '0;
              state_q <= StDone;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    ctrl_o = '0;
    strb_o = '0;
    if (state_q == StRun) begin
      ctrl_o.enable  = 1'b1;
      ctrl_o.realign = mis_q;
      ctrl_o.first   = first_beat;
      ctrl_o.last    = last_beat;
      // The realigner latches its rotation from the first-beat strobe.
      strb_o         = first_beat ? ({NB{1'b1}} << off_q) : {NB{1'b1}};
    end
  end

  assign realign_clear_o = ~rst_i & (clear_i | ((state_q == StIdle) & start_i & size_nz));
  assign busy_o          = (state_q != StIdle);
  assign done_o          = (state_q == StDone);

endmodule

// File: tb/tb_hwpe_stream_realign_ctrl.sv
// Randomized bench for hwpe_stream_realign_ctrl against a job-level reference model.

module tb_hwpe_stream_realign_ctrl;
  import hwpe_stream_realign_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 6;
  localparam int unsigned NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst, clear, start, bv, br;
  logic [31:0]   base;
  logic [CW-1:0] n;
  ctrl_realign_t ctrl;
  logic [NB-1:0] strb;
  logic          rclr, busy, done;

  int checks = 0;
  int failures = 0;

  // Reference model: job in flight, beats seen so far, and a pending done pulse.
  bit m_active, m_done, m_mis;
  int m_total, m_seen, m_off;

  hwpe_stream_realign_ctrl #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .clear_i         (clear),
    .start_i         (start),
    .base_addr_i     (base),
    .trans_size_i    (n),
    .beat_valid_i    (bv),
    .beat_ready_i    (br),
    .ctrl_o          (ctrl),
    .strb_o          (strb),
    .realign_clear_o (rclr),
    .busy_o          (busy),
    .done_o          (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic [NB-1:0] es;
    bit idle;
    @(negedge clk);
    #1;
    idle = !m_active && !m_done;
    es = '0;
    if (m_active) for (int b = 0; b < NB; b++) es[b] = (m_seen != 0) || (b >= m_off);
    check_eq("enable",  ctrl.enable, m_active);
    check_eq("realign", ctrl.realign, m_active && m_mis);
    check_eq("first",   ctrl.first, m_active && m_seen == 0);
    check_eq("last",    ctrl.last, m_active && m_seen == m_total - 1);
    check_eq("strb",    strb, es);
    check_eq("busy",    busy, !idle);
    check_eq("done",    done, m_done);
    check_eq("rclr",    rclr, !rst && (clear || (idle && start && n != 0)));
    @(posedge clk);
    if (rst) begin
      m_active = 0; m_done = 0; m_seen = 0;
    end else if (clear) begin
      m_active = 0; m_done = 0; m_seen = 0;
    end else if (idle) begin
      if (start) begin
        m_off   = base % NB;
        m_mis   = (m_off != 0);
        m_total = int'(n) + (m_mis ? 1 : 0);
        m_seen  = 0;
        if (n != 0) m_active = 1;
        else m_done = 1;
      end
    end else if (m_active) begin
      if (bv && br) begin
        m_seen++;
        if (m_seen == m_total) begin
          m_active = 0; m_done = 1; m_seen = 0;
        end
      end
    end else begin
      m_done = 0;
    end
    #1;
  endtask

  task automatic go(input logic [31:0] b, input int unsigned len);
    base = b; n = CW'(len); start = 1; step(); start = 0;
  endtask

  initial begin
    rst = 1; clear = 0; start = 0; bv = 0; br = 0; base = '0; n = '0;
    m_active = 0; m_done = 0; m_mis = 0; m_total = 0; m_seen = 0; m_off = 0;
    step(); step();
    rst = 0;
    check_eq("rst_ctrl", ctrl, 0);
    check_eq("rst_busy", busy, 0);
    step();

    // Aligned, always ready.
    bv = 1; br = 1;
    go(32'h100, 4);
    check_eq("al_realign", ctrl.realign, 0);
    repeat (4) step();
    check_eq("al_done", done, 1);
    step(); step();

    // Misaligned by 3.
    go(32'h103, 3);
    check_eq("b103_strb0", strb, 4'b1000);
    check_eq("b103_realign", ctrl.realign, 1);
    step();
    check_eq("b103_strb1", strb, 4'b1111);
    repeat (3) step();
    check_eq("b103_done", done, 1);
    step();
    check_eq("b103_idle", busy, 0);

    // Backpressure with ready toggling.
    br = 0;
    go(32'h102, 2);
    check_eq("stall_strb", strb, 4'b1100);
    br = 1; step();
    br = 0; step();
    check_eq("stall_first", ctrl.first, 0);
    check_eq("stall_strb1", strb, 4'b1111);
    br = 1; step();
    br = 0; step();
    check_eq("stall_last", ctrl.last, 1);
    br = 1; step();
    check_eq("stall_done", done, 1);
    step();

    // Zero-length job.
    go(32'h40, 0);
    check_eq("n0_done", done, 1);
    check_eq("n0_en", ctrl.enable, 0);
    step();

    // Clear after two beats, then a full restart.
    go(32'h0, 5);
    step(); step();
    clear = 1; step(); clear = 0;
    check_eq("clr_busy", busy, 0);
    check_eq("clr_done", done, 0);
    go(32'h0, 5);
    check_eq("clr_first", ctrl.first, 1);
    repeat (5) step();
    check_eq("clr_redone", done, 1);
    step();

    // Start while busy must not change the job.
    go(32'h200, 4);
    base = 32'h201; n = 9; start = 1;
    repeat (4) step();
    start = 0;
    check_eq("busy_start_done", done, 1);
    step();

    // Reset mid-job.
    go(32'h10, 6);
    step(); step();
    rst = 1; step(); rst = 0;
    check_eq("mid_rst_ctrl", ctrl, 0);
    check_eq("mid_rst_strb", strb, 0);
    check_eq("mid_rst_busy", busy, 0);
    step();

    // Maximum length, misaligned: counter spans the full CW+1 range.
    go(32'h1, (1 << CW) - 1);
    repeat (1 << CW) step();
    check_eq("max_done", done, 1);
    step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      clear = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 3) == 0);
      base  = $urandom;
      n     = ($urandom_range(0, 15) == 0) ? CW'((1 << CW) - 1) : CW'($urandom_range(0, 7));
      bv    = $urandom_range(0, 3) != 0;
      br    = $urandom_range(0, 2) != 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
